// File: rtl/gold_pkg.sv
// Shared types, default code parameters and helper functions for the Gold code blocks.
package gold_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int unsigned DEF_N      = 63;
  localparam int unsigned DEF_LENGTH = 6;
  localparam logic [5:0]  DEF_POLY1  = 6'b000011;
  localparam logic [5:0]  DEF_POLY2  = 6'b100111;

  // Helpers operate on fixed maximum widths; callers zero-extend narrower values.
  localparam int unsigned LFSR_MAX_W = 16;
  localparam int unsigned POP_MAX_W  = 64;
  localparam int unsigned POP_W      = 7;

  // Fibonacci step: output bit is s[0], feedback enters at bit len-1.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] s,
                                                      input logic [LFSR_MAX_W-1:0] poly,
                                                      input int unsigned           len);
    logic fb;
    fb = ^(s & poly);
    return (s >> 1) | (LFSR_MAX_W'(fb) << (len - 1));
  endfunction

  function automatic logic [POP_W-1:0] popcount(input logic [POP_MAX_W-1:0] v);
    logic [POP_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(POP_MAX_W); i++) cnt = cnt + POP_W'(v[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/axistream_if.sv
// Minimal AXI-stream bundle used for seed loading.
interface axistream_if #(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned USER_W = 6
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [USER_W-1:0] tuser;

  modport slave  (input tvalid, input tdata, input tuser, output tready);
  modport master (output tvalid, output tdata, output tuser, input tready);
endinterface

// File: rtl/gold_lfsr.sv
// Seedable Fibonacci LFSR; a zero seed is forced to 1 so the register never locks up.
module gold_lfsr
  import gold_pkg::*;
#(
  parameter int unsigned       LENGTH = DEF_LENGTH,
  parameter logic [LENGTH-1:0] POLY   = LENGTH'(DEF_POLY1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [LENGTH-1:0] seed_i,
  input  logic              step_i,
  output logic [LENGTH-1:0] state_o,
  output logic              out_o
);

  logic [LENGTH-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = (seed_i == '0) ? LENGTH'(1) : seed_i;
    end else if (step_i) begin
      state_d = LENGTH'(lfsr_next(LFSR_MAX_W'(state_q), LFSR_MAX_W'(POLY), LENGTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= LENGTH'(1);
    else       state_q <= state_d;
  end

  assign state_o = state_q;
  assign out_o   = state_q[0];

endmodule

// File: rtl/gold_code_correlator.sv
// Sliding-window correlator of a received chip stream against a locally generated Gold code.
module gold_code_correlator
  import gold_pkg::*;
#(
  parameter int unsigned       N      = DEF_N,
  parameter int unsigned       LENGTH = $clog2(N),
  parameter logic [LENGTH-1:0] POLY1  = LENGTH'(DEF_POLY1),
  parameter logic [LENGTH-1:0] POLY2  = LENGTH'(DEF_POLY2),
  parameter int unsigned       THRESH = 48,
  parameter int unsigned       CW     = LENGTH + 2
) (
  input  logic                 clkin,
  input  logic                 rst,
  axistream_if.slave           s_axis,
  input  logic                 chip_i,
  input  logic                 chip_valid_i,
  output logic signed [CW-1:0] corr_o,
  output logic                 corr_valid_o,
  output logic                 detect_o,
  output logic                 polarity_o,
  output logic                 busy_o
);

  localparam int unsigned FW = $clog2(N + 1);
  localparam logic signed [CW-1:0] THR_P = CW'(THRESH);
  localparam logic signed [CW-1:0] THR_N = -THR_P;

  state_e                state_q, state_d;
  logic [N-1:0]          ref_q, ref_d;
  logic [N-1:0]          win_q, win_d;
  logic [FW-1:0]         fill_q, fill_d, fill_inc_c;
  logic [FW-1:0]         gcnt_q, gcnt_d;
  logic                  pend_q, pend_d;
  logic signed [CW-1:0]  corr_q, corr_d;
  logic                  cv_q, cv_d, det_q, det_d, pol_q, pol_d;
  logic                  busy_q, busy_d, tready_q, tready_d;

  logic                  load_c, step_c, gold_c, hs_c;
  logic                  out1_c, out2_c;
  logic [LENGTH-1:0]     unused_lfsr1_state, unused_lfsr2_state;
  logic [POP_W-1:0]      pop_c;
  logic signed [CW-1:0]  corr_c;

  gold_lfsr #(.LENGTH(LENGTH), .POLY(POLY1)) u_lfsr1 (
    .clk_i  (clkin),
    .rst_i  (rst),
    .load_i (load_c),
    .seed_i (s_axis.tuser[LENGTH-1:0]),
    .step_i (step_c),
    .state_o(unused_lfsr1_state),
    .out_o  (out1_c)
  );

  gold_lfsr #(.LENGTH(LENGTH), .POLY(POLY2)) u_lfsr2 (
    .clk_i  (clkin),
    .rst_i  (rst),
    .load_i (load_c),
    .seed_i (s_axis.tdata[LENGTH-1:0]),
    .step_i (step_c),
    .state_o(unused_lfsr2_state),
    .out_o  (out2_c)
  );

  assign gold_c     = out1_c ^ out2_c;
  assign hs_c       = s_axis.tvalid & tready_q;
  assign fill_inc_c = (fill_q == FW'(N)) ? fill_q : fill_q + 1'b1;
  // Correlation of the registered window: N - 2*disagreements.
  assign pop_c      = popcount(POP_MAX_W'(win_q ^ ref_q));
  assign corr_c     = CW'(N) - CW'({pop_c, 1'b0});

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    win_d   = win_q;
    fill_d  = fill_q;
    gcnt_d  = gcnt_q;
    pend_d  = 1'b0;
    corr_d  = corr_q;
    cv_d    = 1'b0;
    det_d   = 1'b0;
    pol_d   = pol_q;
    load_c  = 1'b0;
    step_c  = 1'b0;

    // Publish the evaluation for the window updated on the previous edge.
    if (pend_q) begin
      corr_d = corr_c;
      cv_d   = 1'b1;
      if (corr_c >= THR_P) begin
        det_d = 1'b1;
        pol_d = 1'b0;
      end else if (corr_c <= THR_N) begin
        det_d = 1'b1;
        pol_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (hs_c) begin
          load_c  = 1'b1;
          fill_d  = '0;
          gcnt_d  = '0;
          state_d = GEN;
        end
      end
      GEN: begin
        step_c = 1'b1;
        ref_d  = {ref_q[N-2:0], gold_c};
        gcnt_d = gcnt_q + 1'b1;
        if (gcnt_q == FW'(N - 1)) state_d = RUN;
      end
      RUN: begin
        if (hs_c) begin
          load_c  = 1'b1;
          win_d   = '0;
          fill_d  = '0;
          gcnt_d  = '0;
          state_d = GEN;
        end else if (chip_valid_i) begin
          win_d  = {win_q[N-2:0], chip_i};
          fill_d = fill_inc_c;
          pend_d = (fill_inc_c == FW'(N));
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d   = (state_d == GEN);
    tready_d = (state_d != GEN);
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q  <= IDLE;
      ref_q    <= '0;
      win_q    <= '0;
      fill_q   <= '0;
      gcnt_q   <= '0;
      pend_q   <= 1'b0;
      corr_q   <= '0;
      cv_q     <= 1'b0;
      det_q    <= 1'b0;
      pol_q    <= 1'b0;
      busy_q   <= 1'b0;
      tready_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      win_q    <= win_d;
      fill_q   <= fill_d;
      gcnt_q   <= gcnt_d;
      pend_q   <= pend_d;
      corr_q   <= corr_d;
      cv_q     <= cv_d;
      det_q    <= det_d;
      pol_q    <= pol_d;
      busy_q   <= busy_d;
      tready_q <= tready_d;
    end
  end

  assign corr_o        = corr_q;
  assign corr_valid_o  = cv_q;
  assign detect_o      = det_q;
  assign polarity_o    = pol_q;
  assign busy_o        = busy_q;
  assign s_axis.tready = tready_q;

endmodule

// File: doc/gold_code_correlator.md
Name: gold_code_correlator

Overview:
- Receive-side counterpart of the Gold code generator: accepts a serial chip stream and detects alignment with a locally regenerated Gold code.
- Seeds arrive over the same AXI-stream slave convention as the generator: tuser carries the LFSR1 seed, tdata carries the LFSR2 seed.
- After seeding, the block builds an N-chip reference, then slides a correlation window over incoming chips.
- Outputs the signed correlation per chip plus detect and polarity flags; sits after the chip slicer in the despreading path.

Parameters:
N, 63, code length in chips (2^LENGTH - 1)
LENGTH, $clog2(N), LFSR width and seed width
POLY1, 6'b000011, LFSR1 tap mask
POLY2, 6'b100111, LFSR2 tap mask
THRESH, 48, minimum |corr| for detection (1..N)
CW, LENGTH+2, width of the signed correlation output

Ports:
clkin  in  1  clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
s_axis  axistream_if.slave  -  seed load: tdata[LENGTH-1:0] = LFSR2 seed, tuser[LENGTH-1:0] = LFSR1 seed, tvalid/tready handshake
chip_i  in  1  received hard-decision chip
chip_valid_i  in  1  chip_i valid this cycle; no backpressure
corr_o  out  CW signed  correlation = 2*agreements - N, range -N..+N
corr_valid_o  out  1  corr_o updated, single-cycle pulse
detect_o  out  1  single-cycle pulse when |corr| >= THRESH
polarity_o  out  1  sign at last detect: 0 = +, 1 = inverted; held until next detect
busy_o  out  1  high in GEN state

Behaviour:
- Reset: synchronous, active-high, decided. Clock is clkin. While rst=1 at an edge: state=IDLE; all outputs 0; window, ref and fill counter cleared. Overrides every other event in that cycle.
- LFSR, identical for both generators:
  - Output bit = s[0].
  - fb = ^(s & POLY).
  - Next state = {fb, s[LENGTH-1:1]}.
  - Gold chip = out1 ^ out2.
  - A zero seed is replaced by 1.
- States:
  - IDLE: s_axis.tready=1. On tvalid&tready, load both seeds, clear the fill counter, go to GEN.
  - GEN: tready=0 and busy_o=1. Each cycle, shift one Gold chip into ref[0] (ref shifts toward MSB) and step both LFSRs. After exactly N cycles, go to RUN. Chips arriving during GEN are dropped.
  - RUN: tready=1. A seed handshake reloads the seeds, clears the window and fill counter, and returns to GEN. A chip in the same cycle as that handshake is dropped.
- Chip ingest (RUN only), on chip_valid_i:
  - window <= {window[N-2:0], chip_i}.
  - fill counter increments, saturating at N.
- Correlation: agreements = N - popcount(window ^ ref), computed on the registered window. The outputs corr_o, corr_valid_o, detect_o and polarity_o register exactly 1 cycle after the window update.
- Evaluation gating: corr_valid_o fires only once fill == N. The first valid evaluation is for the N-th accepted chip; every later valid chip gives one evaluation.
- Detect: corr >= THRESH gives detect_o=1, polarity_o=0. corr <= -THRESH gives detect_o=1, polarity_o=1.
- Gaps: gaps in chip_valid_i do not disturb the window. corr_o holds its value between evaluations.
- Width: corr is computed as signed CW. No overflow is possible since |corr| <= N < 2^(CW-1).

Decomposition:
- Package gold_pkg holds:
  - state enum {IDLE, GEN, RUN};
  - default N, LENGTH, POLY1 and POLY2 constants;
  - function lfsr_next(state, poly);
  - function popcount.
- One sub-module, gold_lfsr. Parameters: POLY, LENGTH. Ports: load, seed, step, state, out. Instantiated twice. It is reusable by the generator.

Test Plan:
- Seeds tuser=1, tdata=1; after GEN, feed the 63 chips produced by the golden model -> on chip 63: corr_o=+63, detect_o=1, polarity_o=0; busy_o high exactly 63 cycles.
- Same seeds, feed the inverted sequence -> corr_o=-63, detect_o=1, polarity_o=1.
- Feed the sequence cyclically rotated by 1..62 chips -> every |corr_o| matches the golden model and is < 48; no detect_o.
- Feed 62 chips, then hold chip_valid_i low for 10 cycles, then 1 chip -> no corr_valid_o before chip 63; one evaluation after the gap, matching the model.
- Reseed mid-RUN (tuser=5, tdata=9) with chip_valid_i=1 in the handshake cycle -> chip dropped, GEN restarts, the new reference matches the model, and the first evaluation comes after 63 new chips.
- Assert rst during GEN and during RUN with chip_valid_i=1 -> next cycle state IDLE, all outputs 0, tready=1; a zero seed pair behaves as seeds (1,1).
